mem_seq_ctrl: RTL

Sequencing controller for a 16-entry × 4-bit synchronous RAM that uses the addr/data counting pattern from the lab's address/data generators. On a start request it runs the full test:

- writes a seeded ramp into every location;
- reads every location back and compares it against the expected value;
- reports pass/fail and a mismatch count.

It sits between the lab top level (buttons/LEDs) and the RAM macro. It owns the RAM port exclusively while busy.

---
 rtl/mem_seq_pkg.sv | 21 ++
 rtl/mem_seq_cmp.sv | 46 ++++
 rtl/mem_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types, default sizes and expected-pattern helper for the RAM sequencer.
package mem_seq_pkg;

    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned AW_DEF    = 4;
    localparam int unsigned DW_DEF    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    // Ramp pattern value for a location; callers truncate to their data width.
    function automatic logic [31:0] exp_val(input logic [31:0] a, input logic [31:0] s);
        return a + s;
    endfunction

endpackage

// File: rtl/mem_seq_cmp.sv
// Read-back checker: aligns the expected value with the 1-cycle RAM latency and counts mismatches.
module mem_seq_cmp
    import mem_seq_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_seed,
    input  logic [DW-1:0] i_rdata,
    output logic [AW:0]   o_cnt
);

    localparam int unsigned CW = AW + 1;

    logic          r_re_q;
    logic [DW-1:0] r_exp;
    logic [AW:0]   r_cnt;
    logic          w_miss;

    assign w_miss = r_re_q && (i_rdata != r_exp);

    // Delay re/expected alongside the RAM read and accumulate mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_re_q <= 1'b0;
            r_exp  <= '0;
            r_cnt  <= '0;
        end else begin
            r_re_q <= i_re;
            r_exp  <= DW'(exp_val(32'(i_addr), 32'(i_seed)));
            if (i_clr) begin
                r_cnt <= '0;
            end else if (w_miss) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_seq_ctrl.sv
// Write-ramp / read-compare sequencer owning a single-port synchronous RAM while busy.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] seed,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          we,
    output logic          re,
    input  logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_we;
    logic          r_re;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [AW:0]   r_err_cnt;
    logic [DW-1:0] r_seed_q;

    state_t        w_state_d;
    logic [AW-1:0] w_addr_d;
    logic [AW-1:0] w_addr_inc;
    logic [DW-1:0] w_wdata_d;
    logic          w_we_d;
    logic          w_re_d;
    logic          w_busy_d;
    logic          w_done_d;
    logic [DW-1:0] w_seed_d;
    logic          w_clr;
    logic          w_load;
    logic [AW:0]   w_cnt;

    assign w_addr_inc = r_addr + AW'(1);

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        w_state_d = r_state;
        w_addr_d  = '0;
        w_wdata_d = '0;
        w_we_d    = 1'b0;
        w_re_d    = 1'b0;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;
        w_seed_d  = r_seed_q;
        w_clr     = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_d = S_WRITE;
                    w_seed_d  = seed;
                    w_clr     = 1'b1;
                    w_we_d    = 1'b1;
                    w_busy_d  = 1'b1;
                    w_wdata_d = DW'(exp_val(32'd0, 32'(seed)));
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                end else if (r_addr == ADDR_LAST) begin
                    w_state_d = S_READ;
                    w_re_d    = 1'b1;
                    w_busy_d  = 1'b1;
                end else begin
                    w_addr_d  = w_addr_inc;
                    w_we_d    = 1'b1;
                    w_busy_d  = 1'b1;
                    w_wdata_d = DW'(exp_val(32'(w_addr_inc), 32'(r_seed_q)));
                end
            end
            S_READ: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                end else if (r_addr == ADDR_LAST) begin
                    w_state_d = S_WAIT;
                    w_busy_d  = 1'b1;
                end else begin
                    w_addr_d = w_addr_inc;
                    w_re_d   = 1'b1;
                    w_busy_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_state_d = S_DONE;
                    w_done_d  = 1'b1;
                end
            end
            S_DONE: begin
                // Last compare has landed in the counter by now; publish unless aborted.
                w_state_d = S_IDLE;
                w_load    = !abort;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State, output and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_seed_q  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_addr   <= w_addr_d;
            r_wdata  <= w_wdata_d;
            r_we     <= w_we_d;
            r_re     <= w_re_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_seed_q <= w_seed_d;
            if (w_load) begin
                r_err_cnt <= w_cnt;
                r_pass    <= (w_cnt == '0);
            end
        end
    end

    mem_seq_cmp #(
        .AW (AW),
        .DW (DW)
    ) u_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_re    (r_re),
        .i_addr  (r_addr),
        .i_seed  (r_seed_q),
        .i_rdata (rdata),
        .o_cnt   (w_cnt)
    );

    assign addr    = r_addr;
    assign wdata   = r_wdata;
    assign we      = r_we;
    assign re      = r_re;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule
